// File: rtl/conv_bram_1d_ctrl.sv
// conv_bram_1d_ctrl
// Control FSM for the 1-D BRAM convolution datapath. Streams image columns out
// of the image BRAM, shifts them into the datapath window register, tags each
// qualifying window with its result address and write enable, then waits for
// the datapath's last_val before pulsing done.
// Optional feature: define CONV_BRAM_1D_CTRL_PERF_EN to add a 32-bit busy-cycle
// counter output perf_cycles.

module conv_bram_1d_ctrl #(
    parameter int IMG_W    = 32,
    parameter int FILTER_L = 3,
    parameter int STRIDE_W = 1,
    parameter int RD_LAT   = 1,
    localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1,
    localparam int LAST_COL = (RESULT_W - 1) * STRIDE_W + FILTER_L - 1,
    localparam int IMG_RAM_ADDR_WIDTH = $clog2(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             img_rden,
    output logic                             dpath_sr_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
    input  logic                             last_val
`ifdef CONV_BRAM_1D_CTRL_PERF_EN
    ,
    output logic [31:0]                      perf_cycles
`endif
);

    localparam int STRIDE_CW = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;

    localparam logic [IMG_RAM_ADDR_WIDTH-1:0] LAST_ADDR = IMG_RAM_ADDR_WIDTH'(LAST_COL);
    localparam logic [IMG_RAM_ADDR_WIDTH-1:0] FIRST_WIN_COL = IMG_RAM_ADDR_WIDTH'(FILTER_L - 1);
    localparam logic [STRIDE_CW-1:0] STRIDE_RELOAD = STRIDE_CW'(STRIDE_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                           state;
    logic [RD_LAT-1:0]                rd_pipe;
    logic [IMG_RAM_ADDR_WIDTH-1:0]    col_cnt;
    logic [STRIDE_CW-1:0]             stride_cnt;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] result_idx;
    logic                             start_accept;
    logic                             col_in_window;
    logic                             qualify;

    assign start_accept  = (state == ST_IDLE) && start;
    assign col_in_window = dpath_sr_wren && (col_cnt >= FIRST_WIN_COL);
    assign qualify       = col_in_window && (stride_cnt == '0);
    assign dpath_sr_wren = rd_pipe[RD_LAT-1];

    // Run sequencing: accept start, issue consecutive reads, drain, pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            img_rden   <= 1'b0;
            img_rdaddr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_READ;
                        busy       <= 1'b1;
                        img_rden   <= 1'b1;
                        img_rdaddr <= '0;
                    end
                end
                ST_READ: begin
                    if (img_rdaddr == LAST_ADDR) begin
                        state    <= ST_DRAIN;
                        img_rden <= 1'b0;
                    end else begin
                        img_rdaddr <= img_rdaddr + IMG_RAM_ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (last_val) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay line matching the BRAM read latency so shifts line up with read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= img_rden;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end
        end
    end

    // Shifted-column tracking, stride down-counter and result address tagging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_cnt             <= '0;
            stride_cnt          <= '0;
            result_idx          <= '0;
            dpath_result_wren   <= 1'b0;
            dpath_result_wraddr <= '0;
        end else if (start_accept) begin
            col_cnt           <= '0;
            stride_cnt        <= '0;
            result_idx        <= '0;
            dpath_result_wren <= 1'b0;
        end else begin
            dpath_result_wren <= qualify;
            if (dpath_sr_wren) begin
                col_cnt <= col_cnt + IMG_RAM_ADDR_WIDTH'(1);
            end
            if (col_in_window) begin
                stride_cnt <= (stride_cnt == '0) ? STRIDE_RELOAD
                                                 : stride_cnt - STRIDE_CW'(1);
            end
            if (qualify) begin
                dpath_result_wraddr <= result_idx;
                result_idx          <= result_idx + RESULT_RAM_ADDR_WIDTH'(1);
            end
        end
    end

`ifdef CONV_BRAM_1D_CTRL_PERF_EN
    // Busy-cycle counter: cleared on start, saturating, held between runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (start_accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
